// File: rtl/uart_param_xcvr.sv
// -----------------------------------------------------------------------------
// uart_param_xcvr
//   Parameterised UART transceiver with a TX FIFO, an RX FIFO, optional
//   even/odd parity and one stop bit. Frame on the wire:
//   start(0), DATA_W data bits LSB first, [parity], stop(1).
//   Each bit lasts CLKS_PER_BIT clocks.
//
// Parameters
//   DATA_W        data bits per frame (5..8)
//   CLKS_PER_BIT  clocks per serial bit (even, >= 4)
//   FIFO_DEPTH    entries per FIFO (power of 2, >= 2)
//
// Ports
//   CLK, RST         clock, synchronous active-high reset
//   parity_en        1 = parity bit inserted / checked
//   parity_kind      0 = even, 1 = odd
//   rxd              asynchronous serial input, idle high
//   loopback         (only with UART_LOOPBACK_EN) receiver listens to the
//                    internal TX stream and txd is held high
//   txd              serial output, idle high
//   tx_data, tx_wr   TX FIFO write port; tx_full = TX FIFO full
//   rx_data, rx_rd   RX FIFO show-ahead head (0 when empty) and pop strobe
//   rx_empty         RX FIFO empty
//   ft               pulse in the last cycle of each transmitted stop bit
//   fr               pulse in the cycle a received word is pushed
//   perr, ferr       pulses: parity error / framing error
//   rx_ovf           sticky: good frame dropped because the RX FIFO was full
//
// Build option
//   UART_LOOPBACK_EN  adds the loopback input port (after rxd).
// -----------------------------------------------------------------------------
module uart_param_xcvr #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              parity_en,
  input  logic              parity_kind,
  input  logic              rxd,
`ifdef UART_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              txd,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_wr,
  output logic              tx_full,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_rd,
  output logic              rx_empty,
  output logic              ft,
  output logic              fr,
  output logic              perr,
  output logic              ferr,
  output logic              rx_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------------------------------------------------------- TX FIFO
  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [DATA_W-1:0] r_tx_mem [FIFO_DEPTH];
  logic [AW:0]       r_tx_wp, r_tx_rp;
  logic              w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
  logic [DATA_W-1:0] w_tx_head;

  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
  assign w_tx_push  = tx_wr && !w_tx_full;
  assign w_tx_head  = r_tx_mem[r_tx_rp[AW-1:0]];
  assign tx_full    = w_tx_full;

  // NOTE: FIFO storage is deliberately not reset; the pointers alone define
  // which entries are valid, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge CLK) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= tx_data;
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + (AW+1)'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + (AW+1)'(1);
    end
  end

  // ---------------------------------------------------------------- TX FSM
  state_t            r_tx_state, w_tx_next;
  logic [CW-1:0]     r_tx_cnt;
  logic [IW-1:0]     r_tx_idx;
  logic [DATA_W-1:0] r_tx_sh;
  logic              r_tx_par_en, r_tx_par_bit;
  logic              w_tx_bit_end, w_tx_serial;

  assign w_tx_bit_end = (r_tx_cnt == CW'(CLKS_PER_BIT-1));

  always_ff @(posedge CLK) begin
    if (RST) r_tx_state <= S_IDLE;
    else     r_tx_state <= w_tx_next;
  end

  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    case (r_tx_state)
      S_IDLE:   if (!w_tx_empty) begin
                  w_tx_next = S_START;
                  w_tx_pop  = 1'b1;
                end
      S_START:  if (w_tx_bit_end) w_tx_next = S_DATA;
      S_DATA:   if (w_tx_bit_end && r_tx_idx == IW'(DATA_W-1))
                  w_tx_next = r_tx_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_tx_bit_end) w_tx_next = S_STOP;
      S_STOP:   if (w_tx_bit_end) begin
                  // Back-to-back: next start bit follows the stop bit directly.
                  if (!w_tx_empty) begin
                    w_tx_next = S_START;
                    w_tx_pop  = 1'b1;
                  end else begin
                    w_tx_next = S_IDLE;
                  end
                end
      default:  w_tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tx_cnt     <= '0;
      r_tx_idx     <= '0;
      r_tx_sh      <= '0;
      r_tx_par_en  <= 1'b0;
      r_tx_par_bit <= 1'b0;
    end else if (w_tx_pop) begin
      // Frame setup, including the parity configuration for this frame.
      r_tx_cnt     <= '0;
      r_tx_idx     <= '0;
      r_tx_sh      <= w_tx_head;
      r_tx_par_en  <= parity_en;
      r_tx_par_bit <= (^w_tx_head) ^ parity_kind;
    end else if (r_tx_state != S_IDLE) begin
      r_tx_cnt <= w_tx_bit_end ? '0 : r_tx_cnt + CW'(1);
      if (r_tx_state == S_DATA && w_tx_bit_end) begin
        r_tx_sh  <= r_tx_sh >> 1;
        r_tx_idx <= r_tx_idx + IW'(1);
      end
    end
  end

  always_comb begin
    case (r_tx_state)
      S_START:  w_tx_serial = 1'b0;
      S_DATA:   w_tx_serial = r_tx_sh[0];
      S_PARITY: w_tx_serial = r_tx_par_bit;
      default:  w_tx_serial = 1'b1;
    endcase
  end

  assign ft = (r_tx_state == S_STOP) && w_tx_bit_end;

  // ---------------------------------------------------------- line select
  logic w_rx_src;
`ifdef UART_LOOPBACK_EN
  assign w_rx_src = loopback ? w_tx_serial : rxd;
  assign txd      = loopback ? 1'b1 : w_tx_serial;
`else
  assign w_rx_src = rxd;
  assign txd      = w_tx_serial;
`endif

  // ---------------------------------------------------------------- RX FSM
  logic              r_rx_s1, r_rx_s2, r_rx_prev;
  state_t            r_rx_state, w_rx_next;
  logic [CW-1:0]     r_rx_cnt;
  logic [IW-1:0]     r_rx_idx;
  logic [DATA_W-1:0] r_rx_sh;
  logic              r_rx_par_en, r_rx_par_kind, r_rx_par_bit;
  logic              w_rx_fall, w_rx_half, w_rx_bit_end, w_rx_start_ok;
  logic              w_rx_good, w_rx_perr, w_rx_ferr;

  // Synchroniser plus one history flop for falling-edge detection. After a
  // framing error the line is still low, so a new start needs a high first.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= w_rx_src;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  assign w_rx_fall    = r_rx_prev && !r_rx_s2;
  assign w_rx_half    = (r_rx_cnt == CW'(CLKS_PER_BIT/2-1));
  assign w_rx_bit_end = (r_rx_cnt == CW'(CLKS_PER_BIT-1));

  always_ff @(posedge CLK) begin
    if (RST) r_rx_state <= S_IDLE;
    else     r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next     = r_rx_state;
    w_rx_start_ok = 1'b0;
    w_rx_good     = 1'b0;
    w_rx_perr     = 1'b0;
    w_rx_ferr     = 1'b0;
    case (r_rx_state)
      S_IDLE:   if (w_rx_fall) w_rx_next = S_START;
      S_START:  if (w_rx_half) begin
                  if (r_rx_s2) begin
                    w_rx_next = S_IDLE;  // glitch, not a start bit
                  end else begin
                    w_rx_next     = S_DATA;
                    w_rx_start_ok = 1'b1;
                  end
                end
      S_DATA:   if (w_rx_bit_end && r_rx_idx == IW'(DATA_W-1))
                  w_rx_next = r_rx_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_rx_bit_end) w_rx_next = S_STOP;
      S_STOP:   if (w_rx_bit_end) begin
                  w_rx_next = S_IDLE;
                  if (!r_rx_s2)
                    w_rx_ferr = 1'b1;
                  else if (r_rx_par_en && (r_rx_par_bit != ((^r_rx_sh) ^ r_rx_par_kind)))
                    w_rx_perr = 1'b1;
                  else
                    w_rx_good = 1'b1;
                end
      default:  w_rx_next = S_IDLE;
    endcase
  end

  // Counter is zero on the first START cycle, so the half-bit compare lands
  // mid start bit; afterwards full-bit periods land mid of each later bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_cnt      <= '0;
      r_rx_idx      <= '0;
      r_rx_sh       <= '0;
      r_rx_par_en   <= 1'b0;
      r_rx_par_kind <= 1'b0;
      r_rx_par_bit  <= 1'b0;
    end else if (r_rx_state == S_IDLE) begin
      r_rx_cnt <= '0;
    end else if (w_rx_start_ok) begin
      r_rx_cnt      <= '0;
      r_rx_idx      <= '0;
      r_rx_par_en   <= parity_en;
      r_rx_par_kind <= parity_kind;
    end else begin
      r_rx_cnt <= w_rx_bit_end ? '0 : r_rx_cnt + CW'(1);
      if (r_rx_state == S_DATA && w_rx_bit_end) begin
        r_rx_sh  <= {r_rx_s2, r_rx_sh[DATA_W-1:1]};
        r_rx_idx <= r_rx_idx + IW'(1);
      end
      if (r_rx_state == S_PARITY && w_rx_bit_end) r_rx_par_bit <= r_rx_s2;
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [DATA_W-1:0] r_rx_mem [FIFO_DEPTH];
  logic [AW:0]       r_rx_wp, r_rx_rp;
  logic              r_rx_ovf;
  logic              w_rx_empty, w_rx_full, w_rx_push, w_rx_pop;

  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
  assign w_rx_pop   = rx_rd && !w_rx_empty;
  // A simultaneous pop frees the slot being written, so a full FIFO still
  // accepts the push.
  assign w_rx_push  = w_rx_good && (!w_rx_full || w_rx_pop);

  always_ff @(posedge CLK) begin
    if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= r_rx_sh;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_ovf <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + (AW+1)'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + (AW+1)'(1);
      if (w_rx_good && !w_rx_push) r_rx_ovf <= 1'b1;
    end
  end

  assign rx_empty = w_rx_empty;
  assign rx_data  = w_rx_empty ? '0 : r_rx_mem[r_rx_rp[AW-1:0]];
  assign rx_ovf   = r_rx_ovf;
  assign fr       = w_rx_push;
  assign perr     = w_rx_perr;
  assign ferr     = w_rx_ferr;

endmodule

// File: tb/tb_uart_param_xcvr.sv
// -----------------------------------------------------------------------------
// tb_uart_param_xcvr
//   Directed plus randomized bench for uart_param_xcvr (DATA_W=8,
//   CLKS_PER_BIT=4, FIFO_DEPTH=8). Expected wire streams and FIFO contents
//   come from a frame builder and a queue model of the receive FIFO.
//   Build with +define+UART_LOOPBACK_EN to include the loopback step.
// -----------------------------------------------------------------------------
module tb_uart_param_xcvr;

  localparam int DW    = 8;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          parity_en = 1'b0;
  logic          parity_kind = 1'b0;
  logic          rxd = 1'b1;
`ifdef UART_LOOPBACK_EN
  logic          loopback = 1'b0;
`endif
  logic          txd;
  logic [DW-1:0] tx_data = '0;
  logic          tx_wr = 1'b0;
  logic          tx_full;
  logic [DW-1:0] rx_data;
  logic          rx_rd = 1'b0;
  logic          rx_empty;
  logic          ft, fr, perr, ferr, rx_ovf;

  uart_param_xcvr #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .parity_en  (parity_en),
    .parity_kind(parity_kind),
    .rxd        (rxd),
`ifdef UART_LOOPBACK_EN
    .loopback   (loopback),
`endif
    .txd        (txd),
    .tx_data    (tx_data),
    .tx_wr      (tx_wr),
    .tx_full    (tx_full),
    .rx_data    (rx_data),
    .rx_rd      (rx_rd),
    .rx_empty   (rx_empty),
    .ft         (ft),
    .fr         (fr),
    .perr       (perr),
    .ferr       (ferr),
    .rx_ovf     (rx_ovf)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse counters sampled on the falling edge, away from the active edge.
  int n_ft = 0, n_fr = 0, n_perr = 0, n_ferr = 0;
  always @(negedge CLK) begin
    if (!RST) begin
      if (ft)   n_ft++;
      if (fr)   n_fr++;
      if (perr) n_perr++;
      if (ferr) n_ferr++;
    end
  end

  logic [7:0] rx_model [$];
  logic       ovf_model = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Wire image of one frame, bit 0 first. Returns the number of bits.
  function automatic int build_frame(input logic [7:0] d, input logic pen,
                                     input logic pk, output logic [10:0] f);
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    if (pen) begin
      f[9] = (^d) ^ pk;
      return 11;
    end
    return 10;
  endfunction

  // Write one word into an idle transmitter and check the whole wire image.
  task automatic tx_frame(input logic [7:0] d, input logic pen, input logic pk, input string tag);
    logic [10:0] f;
    int          len, ft0;
    len = build_frame(d, pen, pk, f);
    parity_en = pen; parity_kind = pk;
    tx_data = d; tx_wr = 1'b1;
    tick();                              // cycle n+1
    tx_wr = 1'b0;
    check({tag, "_idle_n1"}, txd, 1'b1);
    tick();                              // cycle n+2: start bit
    ft0 = n_ft;
    parity_en = ~pen; parity_kind = ~pk; // mid-frame change must not matter
    for (int b = 0; b < len; b++)
      for (int c = 0; c < CPB; c++) begin
        check($sformatf("%s_bit%0d_c%0d", tag, b, c), txd, f[b]);
        tick();
      end
    check({tag, "_after"}, txd, 1'b1);
    check({tag, "_ft_cnt"}, n_ft - ft0, 1);
  endtask

  // Drive one frame on rxd and report the pulses it produced.
  task automatic rx_frame(input logic [7:0] d, input logic pen, input logic pk,
                          input logic flip_par, input logic bad_stop,
                          output int dfr, output int dperr, output int dferr);
    logic [10:0] f;
    int          len, fr0, pe0, fe0;
    len = build_frame(d, pen, pk, f);
    if (flip_par && pen) f[9] = ~f[9];
    if (bad_stop) f[len-1] = 1'b0;
    parity_en = pen; parity_kind = pk;
    fr0 = n_fr; pe0 = n_perr; fe0 = n_ferr;
    for (int b = 0; b < len; b++) begin
      rxd = f[b];
      repeat (CPB) tick();
    end
    rxd = 1'b1;
    repeat (3*CPB) tick();
    dfr = n_fr - fr0; dperr = n_perr - pe0; dferr = n_ferr - fe0;
  endtask

  task automatic pop_rx();
    rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          dfr, dperr, dferr, ft0, fr0, pe0, fe0, low_cnt;
    logic [7:0]  d;
    logic        pen, pk;
    logic [7:0]  burst [10];
    logic        exp_stream [$];
    logic [10:0] f;
    int          len;

    // ---- reset state
    RST = 1'b1;
    repeat (3) tick();
    check("rst_txd", txd, 1'b1);
    check("rst_tx_full", tx_full, 1'b0);
    check("rst_rx_empty", rx_empty, 1'b1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_pulses", {ft, fr, perr, ferr}, 4'b0000);
    check("rst_rx_ovf", rx_ovf, 1'b0);
    RST = 1'b0;
    repeat (2) tick();

    // ---- transmit: plain, both parities, random
    tx_frame(8'hA5, 1'b0, 1'b0, "tx_a5");
    tx_frame(8'h07, 1'b1, 1'b0, "tx_07_even");
    tx_frame(8'h07, 1'b1, 1'b1, "tx_07_odd");
    repeat (3) begin
      d = 8'($urandom); pen = 1'($urandom); pk = 1'($urandom);
      tx_frame(d, pen, pk, $sformatf("tx_rnd_%02h", d));
    end

    // ---- receive: good, bad parity, bad stop
    rx_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, dfr, dperr, dferr);
    check("rx3c_fr", dfr, 1);
    check("rx3c_perr", dperr, 0);
    check("rx3c_ferr", dferr, 0);
    check("rx3c_empty", rx_empty, 1'b0);
    check("rx3c_data", rx_data, 8'h3C);
    pop_rx();
    check("rx3c_popped", rx_empty, 1'b1);
    check("rx3c_data0", rx_data, 8'h00);

    rx_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, dfr, dperr, dferr);
    check("rxpar_perr", dperr, 1);
    check("rxpar_fr", dfr, 0);
    check("rxpar_empty", rx_empty, 1'b1);

    rx_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, dfr, dperr, dferr);
    check("rxstop_ferr", dferr, 1);
    check("rxstop_fr", dfr, 0);
    check("rxstop_perr", dperr, 0);
    check("rxstop_empty", rx_empty, 1'b1);

    // ---- short low glitch must abort silently
    fr0 = n_fr; pe0 = n_perr; fe0 = n_ferr;
    rxd = 1'b0;
    tick();
    rxd = 1'b1;
    repeat (6*CPB) tick();
    check("glitch_flags", (n_fr - fr0) + (n_perr - pe0) + (n_ferr - fe0), 0);
    check("glitch_empty", rx_empty, 1'b1);

    // ---- random good frames, read back one by one
    repeat (4) begin
      d = 8'($urandom); pen = 1'($urandom); pk = 1'($urandom);
      rx_frame(d, pen, pk, 1'b0, 1'b0, dfr, dperr, dferr);
      check("rxrnd_fr", dfr, 1);
      check("rxrnd_err", dperr + dferr, 0);
      check("rxrnd_data", rx_data, d);
      pop_rx();
    end

    // ---- pop on empty is ignored
    pop_rx();
    check("rdempty_empty", rx_empty, 1'b1);
    check("rdempty_data", rx_data, 8'h00);

    // ---- overflow: DEPTH+1 frames, no reads
    for (int i = 0; i < DEPTH + 1; i++) begin
      d = 8'($urandom); pk = 1'($urandom);
      rx_frame(d, 1'b1, pk, 1'b0, 1'b0, dfr, dperr, dferr);
      if (rx_model.size() < DEPTH) begin
        rx_model.push_back(d);
        check("ovf_fr", dfr, 1);
      end else begin
        ovf_model = 1'b1;
        check("ovf_fr_dropped", dfr, 0);
      end
      check("ovf_flag", rx_ovf, ovf_model);
    end
    while (rx_model.size() > 0) begin
      check("ovf_rd_empty", rx_empty, 1'b0);
      check("ovf_rd_data", rx_data, rx_model.pop_front());
      pop_rx();
    end
    check("ovf_drained", rx_empty, 1'b1);
    check("ovf_sticky", rx_ovf, 1'b1);

    // ---- TX burst: 10 writes on consecutive cycles into a depth-8 FIFO.
    // One word leaves for the transmitter before the FIFO fills, so DEPTH+1
    // words are accepted and sent back to back; the last write is dropped.
    parity_en = 1'b0;
    for (int i = 0; i < 10; i++) burst[i] = 8'($urandom);
    for (int w = 0; w < DEPTH + 1; w++) begin
      len = build_frame(burst[w], 1'b0, 1'b0, f);
      for (int b = 0; b < len; b++)
        repeat (CPB) exp_stream.push_back(f[b]);
    end
    ft0 = n_ft;
    for (int c = 0; c < exp_stream.size() + 12; c++) begin
      if (c < 10) begin
        tx_data = burst[c]; tx_wr = 1'b1;
        if (c == 9) check("burst_tx_full", tx_full, 1'b1);
      end else begin
        tx_wr = 1'b0;
      end
      if (c < 2)
        check("burst_pre_idle", txd, 1'b1);
      else if (c - 2 < exp_stream.size())
        check($sformatf("burst_c%0d", c), txd, exp_stream[c-2]);
      else
        check("burst_post_idle", txd, 1'b1);
      tick();
    end
    check("burst_ft_cnt", n_ft - ft0, DEPTH + 1);
    check("burst_tx_full_end", tx_full, 1'b0);

    // ---- reset mid-frame: frame and queued word are lost
    tx_data = 8'($urandom); tx_wr = 1'b1;
    tick();
    tx_data = 8'($urandom);
    tick();
    tx_wr = 1'b0;
    repeat (15) tick();
    RST = 1'b1;
    tick();
    check("midrst_txd", txd, 1'b1);
    check("midrst_ovf", rx_ovf, 1'b0);
    check("midrst_tx_full", tx_full, 1'b0);
    check("midrst_rx_empty", rx_empty, 1'b1);
    RST = 1'b0;
    ft0 = n_ft;
    low_cnt = 0;
    repeat (60) begin
      tick();
      if (txd !== 1'b1) low_cnt++;
    end
    check("midrst_quiet", low_cnt, 0);
    check("midrst_ft", n_ft - ft0, 0);

`ifdef UART_LOOPBACK_EN
    // ---- loopback: word goes round internally, txd stays high
    loopback = 1'b1;
    parity_en = 1'b0;
    fr0 = n_fr;
    tx_data = 8'h5A; tx_wr = 1'b1;
    tick();
    tx_wr = 1'b0;
    low_cnt = 0;
    repeat (60) begin
      tick();
      if (txd !== 1'b1) low_cnt++;
    end
    check("lb_txd_high", low_cnt, 0);
    check("lb_fr", n_fr - fr0, 1);
    check("lb_rx_empty", rx_empty, 1'b0);
    check("lb_rx_data", rx_data, 8'h5A);
    pop_rx();
    loopback = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
